// File: rtl/spi_sram_access_controller_pkg.sv
// Shared encodings for the SPI-to-SRAM access controller: header commands,
// FSM states and bit offsets of the {cmd, addr, data} MOSI word.
package spi_access_pkg;

   typedef enum logic [1:0] {
      CMD_NOP   = 2'b00,
      CMD_WRITE = 2'b01,
      CMD_BURST = 2'b10,
      CMD_READ  = 2'b11
   } cmd_e;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      BURST_WAIT,
      BURST_WRITE,
      READ_ISSUE,
      READ_WAIT
   } state_e;

   localparam int CMD_W    = 2;
   localparam int DATA_LSB = 0;

   // Address sits directly above data; cmd sits above address.
   function automatic int addr_lsb(input int data_w);
      return data_w;
   endfunction

   function automatic int cmd_lsb(input int data_w, input int addr_w);
      return data_w + addr_w;
   endfunction

endpackage

// File: rtl/rising_edge_pulse.sv
// One-cycle pulse on a rising edge of an already-synchronised level.
// Clearing through enable keeps the history at 0.
module rising_edge_pulse (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic level,
   output logic pulse
);

   logic hist;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         hist <= 1'b0;
      else if (!enable) hist <= 1'b0;
      else              hist <= level;
   end

   assign pulse = enable & level & ~hist;

endmodule

// File: rtl/spi_sram_access_controller.sv
// Decodes SPI words into SRAM writes, bursts and reads, and fills the MISO
// holding register. Define SPI_SRAM_ACCESS_DROP_COUNT_EN to add drop_count.
module spi_sram_access_controller
   import spi_access_pkg::*;
#(
   parameter int DATA_WIDTH        = 32,
   parameter int ADDR_WIDTH        = 10,
   parameter int LEN_WIDTH         = 8,
   parameter int SRAM_READ_LATENCY = 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             enable_configuration,
   input  logic                             write_new,
   input  logic                             read_sync,
   input  logic [2+ADDR_WIDTH+DATA_WIDTH-1:0] mosi_word,
   output logic                             sram_cs,
   output logic                             sram_we,
   output logic [ADDR_WIDTH-1:0]            sram_addr,
   output logic [DATA_WIDTH-1:0]            sram_wdata,
   input  logic [DATA_WIDTH-1:0]            sram_rdata,
   output logic [DATA_WIDTH-1:0]            miso_data,
   output logic                             miso_valid,
   output logic                             busy,
`ifdef SPI_SRAM_ACCESS_DROP_COUNT_EN
   output logic                             overrun,
   output logic [7:0]                       drop_count
`else
   output logic                             overrun
`endif
);

   localparam int ADDR_LSB = addr_lsb(DATA_WIDTH);
   localparam int CMD_LSB  = cmd_lsb(DATA_WIDTH, ADDR_WIDTH);
   localparam logic [1:0] WAIT_LAST = 2'(SRAM_READ_LATENCY - 1);

   cmd_e                  cmd;
   logic [ADDR_WIDTH-1:0] f_addr;
   logic [DATA_WIDTH-1:0] f_data;
   logic [LEN_WIDTH-1:0]  f_len;

   assign cmd    = cmd_e'(mosi_word[CMD_LSB +: CMD_W]);
   assign f_addr = mosi_word[ADDR_LSB +: ADDR_WIDTH];
   assign f_data = mosi_word[DATA_LSB +: DATA_WIDTH];
   assign f_len  = mosi_word[DATA_LSB +: LEN_WIDTH];

   state_e                state, state_n;
   logic [ADDR_WIDTH-1:0] addr_cnt, addr_cnt_n;
   logic [ADDR_WIDTH-1:0] waddr, waddr_n;
   logic [DATA_WIDTH-1:0] wdata, wdata_n;
   logic [LEN_WIDTH-1:0]  cnt, cnt_n;
   logic [1:0]            wait_cnt, wait_cnt_n;
   logic [DATA_WIDTH-1:0] miso_data_n;
   logic                  miso_valid_n;
   logic                  pending, pending_n;
   logic                  overrun_n;
   logic                  rs_pulse;
   logic                  drop, overflow, service, latch;
`ifdef SPI_SRAM_ACCESS_DROP_COUNT_EN
   logic [7:0]            drop_count_n;
   logic [8:0]            drop_sum;
`endif

   rising_edge_pulse u_read_edge (
      .clk    (clk),
      .rst    (rst),
      .enable (enable_configuration),
      .level  (read_sync),
      .pulse  (rs_pulse)
   );

   always_comb begin
      state_n      = state;
      addr_cnt_n   = addr_cnt;
      waddr_n      = waddr;
      wdata_n      = wdata;
      cnt_n        = cnt;
      wait_cnt_n   = wait_cnt;
      miso_data_n  = miso_data;
      miso_valid_n = miso_valid;
      pending_n    = pending;
      overrun_n    = overrun;
      drop         = 1'b0;
      overflow     = 1'b0;
      service      = 1'b0;
      latch        = 1'b0;
`ifdef SPI_SRAM_ACCESS_DROP_COUNT_EN
      drop_count_n = drop_count;
      drop_sum     = '0;
`endif
      if (!enable_configuration) begin
         state_n      = IDLE;
         cnt_n        = '0;
         pending_n    = 1'b0;
         overrun_n    = 1'b0;
         miso_valid_n = 1'b0;
`ifdef SPI_SRAM_ACCESS_DROP_COUNT_EN
         drop_count_n = '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (write_new) begin
                  case (cmd)
                     CMD_WRITE: begin
                        state_n = WRITE;
                        waddr_n = f_addr;
                        wdata_n = f_data;
                     end
                     CMD_BURST: begin
                        addr_cnt_n = f_addr;
                        cnt_n      = f_len;
                        if (f_len != '0) state_n = BURST_WAIT;
                     end
                     CMD_READ: begin
                        addr_cnt_n = f_addr;
                        state_n    = READ_ISSUE;
                     end
                     default: ;
                  endcase
               end else if (pending || (rs_pulse && miso_valid)) begin
                  state_n = READ_ISSUE;
                  service = 1'b1;
               end
            end
            WRITE: state_n = IDLE;
            BURST_WAIT: begin
               if (write_new) begin
                  wdata_n = f_data;
                  state_n = BURST_WRITE;
               end
            end
            BURST_WRITE: begin
               addr_cnt_n = addr_cnt + ADDR_WIDTH'(1);
               cnt_n      = cnt - LEN_WIDTH'(1);
               state_n    = (cnt == LEN_WIDTH'(1)) ? IDLE : BURST_WAIT;
            end
            READ_ISSUE: begin
               miso_valid_n = 1'b0;
               wait_cnt_n   = '0;
               state_n      = READ_WAIT;
            end
            READ_WAIT: begin
               if (wait_cnt == WAIT_LAST) begin
                  miso_data_n  = sram_rdata;
                  miso_valid_n = 1'b1;
                  addr_cnt_n   = addr_cnt + ADDR_WIDTH'(1);
                  state_n      = IDLE;
               end else begin
                  wait_cnt_n = wait_cnt + 2'd1;
               end
            end
            default: state_n = IDLE;
         endcase

         drop = write_new && (state inside {WRITE, BURST_WRITE, READ_ISSUE, READ_WAIT});
         // In quiet IDLE without a pending request the edge is consumed or
         // ignored directly; everywhere else it has to wait its turn.
         latch     = rs_pulse && !(state == IDLE && !write_new && !pending);
         overflow  = latch && pending && !service;
         pending_n = (pending && !service) || latch;
         if (drop || overflow) overrun_n = 1'b1;
`ifdef SPI_SRAM_ACCESS_DROP_COUNT_EN
         drop_sum     = {1'b0, drop_count} + 9'(drop) + 9'(overflow);
         drop_count_n = drop_sum[8] ? 8'hFF : drop_sum[7:0];
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         addr_cnt   <= '0;
         waddr      <= '0;
         wdata      <= '0;
         cnt        <= '0;
         wait_cnt   <= '0;
         miso_data  <= '0;
         miso_valid <= 1'b0;
         pending    <= 1'b0;
         overrun    <= 1'b0;
`ifdef SPI_SRAM_ACCESS_DROP_COUNT_EN
         drop_count <= '0;
`endif
      end else begin
         state      <= state_n;
         addr_cnt   <= addr_cnt_n;
         waddr      <= waddr_n;
         wdata      <= wdata_n;
         cnt        <= cnt_n;
         wait_cnt   <= wait_cnt_n;
         miso_data  <= miso_data_n;
         miso_valid <= miso_valid_n;
         pending    <= pending_n;
         overrun    <= overrun_n;
`ifdef SPI_SRAM_ACCESS_DROP_COUNT_EN
         drop_count <= drop_count_n;
`endif
      end
   end

   // Strobes decode straight from the state register so an async reset
   // removes them in the same instant.
   assign sram_cs    = state inside {WRITE, BURST_WRITE, READ_ISSUE};
   assign sram_we    = state inside {WRITE, BURST_WRITE};
   assign sram_addr  = (state == WRITE) ? waddr : addr_cnt;
   assign sram_wdata = wdata;
   assign busy       = !(state inside {IDLE, BURST_WAIT});

endmodule

// File: tb/tb_spi_sram_access_controller.sv
// Directed self-checking bench for spi_sram_access_controller with a
// one-cycle-latency SRAM model.
module tb_spi_sram_access_controller;
   import spi_access_pkg::*;

   localparam int DW = 32;
   localparam int AW = 10;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              enable_configuration = 1'b1;
   logic              write_new = 1'b0;
   logic              read_sync = 1'b0;
   logic [2+AW+DW-1:0] mosi_word = '0;
   logic              sram_cs, sram_we;
   logic [AW-1:0]     sram_addr;
   logic [DW-1:0]     sram_wdata, sram_rdata, miso_data;
   logic              miso_valid, busy, overrun;
`ifdef SPI_SRAM_ACCESS_DROP_COUNT_EN
   logic [7:0]        drop_count;
`endif

   logic [DW-1:0]     mem [1024];
   int                checks = 0;
   int                errors = 0;

   spi_sram_access_controller #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(8), .SRAM_READ_LATENCY(1)
   ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .enable_configuration (enable_configuration),
      .write_new            (write_new),
      .read_sync            (read_sync),
      .mosi_word            (mosi_word),
      .sram_cs              (sram_cs),
      .sram_we              (sram_we),
      .sram_addr            (sram_addr),
      .sram_wdata           (sram_wdata),
      .sram_rdata           (sram_rdata),
      .miso_data            (miso_data),
      .miso_valid           (miso_valid),
      .busy                 (busy),
`ifdef SPI_SRAM_ACCESS_DROP_COUNT_EN
      .overrun              (overrun),
      .drop_count           (drop_count)
`else
      .overrun              (overrun)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (sram_cs && sram_we)  mem[sram_addr] <= sram_wdata;
      if (sram_cs && !sram_we) sram_rdata <= mem[sram_addr];
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] c, input logic [AW-1:0] a, input logic [DW-1:0] d);
      mosi_word = {c, a, d};
      write_new = 1'b1;
   endtask

   task automatic send(input logic [1:0] c, input logic [AW-1:0] a, input logic [DW-1:0] d);
      drive(c, a, d);
      tick();
      write_new = 1'b0;
   endtask

   task automatic test_reset;
      #3;
      checks++;
      if ({sram_cs, sram_we, sram_addr, sram_wdata, miso_data, miso_valid, busy, overrun} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: cs=%b we=%b addr=%h wdata=%h miso=%h mv=%b busy=%b ovr=%b, want all 0",
                  sram_cs, sram_we, sram_addr, sram_wdata, miso_data, miso_valid, busy, overrun);
      end
`ifdef SPI_SRAM_ACCESS_DROP_COUNT_EN
      checks++;
      if (drop_count !== 8'd0) begin
         errors++;
         $display("FAIL reset_drop_count: got %0d want 0", drop_count);
      end
`endif
      @(negedge clk);
      rst = 1'b1;
      tick();
   endtask

   task automatic test_write;
      send(CMD_WRITE, 10'h005, 32'hDEADBEEF);
      checks++;
      if ({sram_cs, sram_we, busy} !== 3'b111 || sram_addr !== 10'h005 || sram_wdata !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL write_strobe: cs=%b we=%b busy=%b addr=%h wdata=%h, want 1 1 1 005 deadbeef",
                  sram_cs, sram_we, busy, sram_addr, sram_wdata);
      end
      tick();
      checks++;
      if ({sram_cs, busy} !== 2'b00 || mem[5] !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL write_single: cs=%b busy=%b mem=%h, want 0 0 deadbeef", sram_cs, busy, mem[5]);
      end
   endtask

   task automatic test_burst;
      logic [DW-1:0] bd [3];
      logic [AW-1:0] ba [3];
      bd = '{32'hA1A1A1A1, 32'hB2B2B2B2, 32'hC3C3C3C3};
      ba = '{10'h3FE, 10'h3FF, 10'h000};
      send(CMD_BURST, 10'h3FE, 32'd3);
      checks++;
      if ({sram_cs, busy} !== 2'b00) begin
         errors++;
         $display("FAIL burst_wait: cs=%b busy=%b, want 0 0", sram_cs, busy);
      end
      for (int i = 0; i < 3; i++) begin
         // cmd/addr fields of data words must be ignored
         send(CMD_READ, 10'h155, bd[i]);
         checks++;
         if ({sram_cs, sram_we} !== 2'b11 || sram_addr !== ba[i] || sram_wdata !== bd[i]) begin
            errors++;
            $display("FAIL burst_word%0d: cs=%b we=%b addr=%h wdata=%h, want 1 1 %h %h",
                     i, sram_cs, sram_we, sram_addr, sram_wdata, ba[i], bd[i]);
         end
         tick();
      end
      send(CMD_WRITE, 10'h020, 32'h44444444);
      checks++;
      if ({sram_cs, sram_we} !== 2'b11 || sram_addr !== 10'h020 || sram_wdata !== 32'h44444444) begin
         errors++;
         $display("FAIL burst_after_header: cs=%b we=%b addr=%h wdata=%h, want 1 1 020 44444444",
                  sram_cs, sram_we, sram_addr, sram_wdata);
      end
      tick();
      checks++;
      if (mem[10'h3FE] !== 32'hA1A1A1A1 || mem[10'h3FF] !== 32'hB2B2B2B2 || mem[0] !== 32'hC3C3C3C3) begin
         errors++;
         $display("FAIL burst_mem: got %h %h %h want a1a1a1a1 b2b2b2b2 c3c3c3c3",
                  mem[10'h3FE], mem[10'h3FF], mem[0]);
      end
   endtask

   task automatic test_read;
      send(CMD_WRITE, 10'h010, 32'h11111111);
      tick();
      send(CMD_WRITE, 10'h011, 32'h22222222);
      tick();
      send(CMD_READ, 10'h010, 32'h0);
      checks++;
      if ({sram_cs, sram_we, busy} !== 3'b101 || sram_addr !== 10'h010) begin
         errors++;
         $display("FAIL read_issue: cs=%b we=%b busy=%b addr=%h, want 1 0 1 010", sram_cs, sram_we, busy, sram_addr);
      end
      tick();
      checks++;
      if (miso_valid !== 1'b0) begin
         errors++;
         $display("FAIL read_early_valid: got %b want 0", miso_valid);
      end
      tick();
      checks++;
      if (miso_valid !== 1'b1 || miso_data !== 32'h11111111) begin
         errors++;
         $display("FAIL read_data: mv=%b data=%h, want 1 11111111", miso_valid, miso_data);
      end
      read_sync = 1'b1;
      tick();
      read_sync = 1'b0;
      checks++;
      if ({sram_cs, sram_we} !== 2'b10 || sram_addr !== 10'h011) begin
         errors++;
         $display("FAIL prefetch_issue: cs=%b we=%b addr=%h, want 1 0 011", sram_cs, sram_we, sram_addr);
      end
      tick();
      tick();
      checks++;
      if (miso_valid !== 1'b1 || miso_data !== 32'h22222222 || busy !== 1'b0) begin
         errors++;
         $display("FAIL prefetch_data: mv=%b data=%h busy=%b, want 1 22222222 0", miso_valid, miso_data, busy);
      end
   endtask

   task automatic test_overrun;
      tick();
      drive(CMD_READ, 10'h010, 32'h0);
      read_sync = 1'b1;
      tick();
      write_new = 1'b0;
      read_sync = 1'b0;
      tick();
      read_sync = 1'b1;
      drive(CMD_WRITE, 10'h010, 32'h0BAD0BAD);
      tick();
      write_new = 1'b0;
      read_sync = 1'b0;
      checks++;
      if (overrun !== 1'b1 || miso_valid !== 1'b1 || miso_data !== 32'h11111111) begin
         errors++;
         $display("FAIL overrun_set: ovr=%b mv=%b data=%h, want 1 1 11111111", overrun, miso_valid, miso_data);
      end
`ifdef SPI_SRAM_ACCESS_DROP_COUNT_EN
      checks++;
      if (drop_count !== 8'd2) begin
         errors++;
         $display("FAIL drop_count: got %0d want 2", drop_count);
      end
`endif
      tick();
      checks++;
      if ({sram_cs, sram_we} !== 2'b10 || sram_addr !== 10'h011) begin
         errors++;
         $display("FAIL pending_service: cs=%b we=%b addr=%h, want 1 0 011", sram_cs, sram_we, sram_addr);
      end
      tick();
      tick();
      checks++;
      if (miso_data !== 32'h22222222 || overrun !== 1'b1 || mem[10'h010] !== 32'h11111111) begin
         errors++;
         $display("FAIL overrun_after: data=%h ovr=%b mem010=%h, want 22222222 1 11111111",
                  miso_data, overrun, mem[10'h010]);
      end
   endtask

   task automatic test_enable_flush;
      enable_configuration = 1'b0;
      tick();
      checks++;
      if ({overrun, miso_valid, busy} !== 3'b000 || miso_data !== 32'h22222222) begin
         errors++;
         $display("FAIL enable_clear: ovr=%b mv=%b busy=%b data=%h, want 0 0 0 22222222",
                  overrun, miso_valid, busy, miso_data);
      end
`ifdef SPI_SRAM_ACCESS_DROP_COUNT_EN
      checks++;
      if (drop_count !== 8'd0) begin
         errors++;
         $display("FAIL enable_drop_count: got %0d want 0", drop_count);
      end
`endif
      enable_configuration = 1'b1;
      send(CMD_BURST, 10'h100, 32'd4);
      send(CMD_NOP, 10'h0, 32'hA5A5A5A5);
      checks++;
      if (sram_cs !== 1'b1 || sram_addr !== 10'h100) begin
         errors++;
         $display("FAIL flush_burst_first: cs=%b addr=%h, want 1 100", sram_cs, sram_addr);
      end
      tick();
      enable_configuration = 1'b0;
      tick();
      enable_configuration = 1'b1;
      send(CMD_WRITE, 10'h200, 32'h00000077);
      checks++;
      if ({sram_cs, sram_we} !== 2'b11 || sram_addr !== 10'h200 || sram_wdata !== 32'h77 ||
          overrun !== 1'b0 || miso_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_header: cs=%b we=%b addr=%h wdata=%h ovr=%b mv=%b, want 1 1 200 77 0 0",
                  sram_cs, sram_we, sram_addr, sram_wdata, overrun, miso_valid);
      end
      tick();
   endtask

   task automatic test_reset_mid_burst;
      send(CMD_BURST, 10'h050, 32'd2);
      send(CMD_NOP, 10'h0, 32'h55555555);
      checks++;
      if (sram_cs !== 1'b1 || sram_addr !== 10'h050) begin
         errors++;
         $display("FAIL rst_burst_strobe: cs=%b addr=%h, want 1 050", sram_cs, sram_addr);
      end
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if ({sram_cs, sram_we, sram_addr, sram_wdata, miso_data, miso_valid, busy, overrun} !== '0) begin
         errors++;
         $display("FAIL rst_abort: cs=%b we=%b addr=%h wdata=%h miso=%h mv=%b busy=%b ovr=%b, want all 0",
                  sram_cs, sram_we, sram_addr, sram_wdata, miso_data, miso_valid, busy, overrun);
      end
      @(negedge clk);
      rst = 1'b1;
      tick();
      send(CMD_WRITE, 10'h060, 32'h66666666);
      checks++;
      if ({sram_cs, sram_we} !== 2'b11 || sram_addr !== 10'h060) begin
         errors++;
         $display("FAIL rst_then_header: cs=%b we=%b addr=%h, want 1 1 060", sram_cs, sram_we, sram_addr);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_write();
      test_burst();
      test_read();
      test_overrun();
      test_enable_flush();
      test_reset_mid_burst();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_sram_access_controller.md
Name: spi_sram_access_controller

Overview:
- Clock-domain consumer directly downstream of the SPI clock-barrier crossing; runs entirely in the `clk` domain.
- Inputs are the `write_new` one-cycle pulse and the synchronised `read_sync` level, plus the quasi-static SPI shift-register word.
- Decodes each received word as a header or as burst data, drives single-port SRAM write/read strobes with address auto-increment, and fills the MISO holding register for the SPI side to shift out.

Parameters:
- DATA_WIDTH, 32, SRAM word width and data field width.
- ADDR_WIDTH, 10, SRAM address width.
- LEN_WIDTH, 8, burst length field width (LEN_WIDTH <= DATA_WIDTH).
- SRAM_READ_LATENCY, 1, cycles from read strobe to valid `sram_rdata` (1..4).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- enable_configuration  in  1  block enable; low = synchronous flush to IDLE.
- write_new  in  1  one-cycle pulse; `mosi_word` valid this cycle.
- read_sync  in  1  synchronised SPI load-MISO level.
- mosi_word  in  2+ADDR_WIDTH+DATA_WIDTH  {cmd[1:0], addr, data}; stable for ≥1 cycle around `write_new`.
- sram_cs  out  1  SRAM access strobe.
- sram_we  out  1  write enable (qualifies `sram_cs`).
- sram_addr  out  ADDR_WIDTH  SRAM address.
- sram_wdata  out  DATA_WIDTH  SRAM write data.
- sram_rdata  in  DATA_WIDTH  SRAM read data.
- miso_data  out  DATA_WIDTH  MISO holding register.
- miso_valid  out  1  `miso_data` holds fetched data.
- busy  out  1  FSM not in IDLE or BURST_WAIT.
- overrun  out  1  sticky: a word was dropped.

Behaviour:
- Reset: all outputs 0, FSM IDLE, address counter 0, burst count 0, `read_sync` history 0.
- Commands (header word, outside burst):
  - 00 NOP.
  - 01 WRITE: write data to addr.
  - 10 BURST_WRITE: load address counter = addr and burst count = data[LEN_WIDTH-1:0]; count 0 = no burst.
  - 11 READ: fetch addr into `miso_data`.
- FSM states: IDLE, WRITE, BURST_WAIT, BURST_WRITE, READ_ISSUE, READ_WAIT.
- IDLE + `write_new`:
  - cmd 01 → WRITE.
  - cmd 10 with nonzero count → BURST_WAIT.
  - cmd 11 → READ_ISSUE.
  - cmd 00, or cmd 10 with count 0 → stay IDLE.
- WRITE: `sram_cs`=`sram_we`=1 for exactly one cycle, then IDLE. Strobe occurs the cycle after `write_new`.
- BURST_WAIT + `write_new`: entire `mosi_word` low DATA_WIDTH bits are data; cmd/addr fields ignored → BURST_WRITE.
- BURST_WRITE: one-cycle write at the address counter, then:
  - address += 1 (wraps 2^ADDR_WIDTH-1 → 0);
  - count -= 1;
  - count reaches 0 → IDLE, else → BURST_WAIT.
- READ_ISSUE: `sram_cs`=1, `sram_we`=0 for one cycle; clear `miso_valid`; address counter = addr; → READ_WAIT.
- READ_WAIT: wait SRAM_READ_LATENCY cycles, capture `sram_rdata` into `miso_data`, set `miso_valid`, increment address counter (with wrap), → IDLE.
  - Latency check: `miso_valid` rises SRAM_READ_LATENCY+2 cycles after `write_new`.
- Prefetch: a rising edge of `read_sync` (internal history register) while `miso_valid`=1 and FSM IDLE → READ_ISSUE at the address counter. This is the sequential-read prefetch.
  - Rising edge while FSM busy: latched as pending, serviced on return to IDLE.
  - At most one pending; a further edge sets `overrun`.
- Drops: `write_new` while in WRITE, BURST_WRITE, READ_ISSUE or READ_WAIT → word dropped, `overrun`=1.
- Simultaneous `write_new` and `read_sync` edge in IDLE: the header wins, the edge becomes pending.
- `overrun` clears only on reset or `enable_configuration` low.
- `enable_configuration` low: next edge forces IDLE and clears burst count, pending, `overrun`, `miso_valid` and SRAM strobes. `miso_data` keeps its value. All inputs are ignored while low.
- Reset mid-burst or mid-read: immediate abort; no partial SRAM strobe after `rst` asserts.

Optional Feature:
- Macro: SPI_SRAM_ACCESS_DROP_COUNT_EN.
- Defined: adds output `drop_count[7:0]`. It increments (saturating at 255) on every dropped word or overflowed read edge, clears like `overrun`, and resets to 0.
- Undefined: no port, no counter; `overrun` only.

Decomposition:
- Package `spi_access_pkg`:
  - command encodings CMD_NOP/CMD_WRITE/CMD_BURST/CMD_READ;
  - FSM state enum;
  - `mosi_word` field offset constants.
- Sub-module `rising_edge_pulse`: registered history of `read_sync`, one-cycle output pulse, async active-low reset, synchronous enable clear. Used once here; reusable elsewhere.

Test Plan:
- WRITE header {01, addr 0x005, data 0xDEADBEEF} → one cycle `sram_cs`=`sram_we`=1, `sram_addr`=0x005, `sram_wdata`=0xDEADBEEF, the cycle after `write_new`.
- BURST header {10, 0x3FE, len 3}, then 3 data words A, B, C → writes at 0x3FE, 0x3FF, 0x000 (wrap); FSM IDLE after the third write; a 4th word is treated as a header.
- READ header addr 0x010, SRAM preloaded 0x11111111/0x22222222 at 0x010/0x011 → `miso_data`=0x11111111 with `miso_valid` at latency+2. A `read_sync` rise then gives `miso_data`=0x22222222.
- `write_new` during READ_WAIT, and two `read_sync` edges during a busy read → `overrun`=1; `drop_count`=2 with SPI_SRAM_ACCESS_DROP_COUNT_EN; SRAM contents unchanged.
- `enable_configuration` dropped mid-burst (after 1 of 4 words) → IDLE; next word decoded as a header; `overrun` and `miso_valid` are 0.
- `rst` asserted during a BURST_WRITE strobe → `sram_cs`=0 immediately; all outputs 0.
